// File: rtl/shift_seq_pkg.sv
// Shared encodings, state enum and stage weights for the shift sequencer.
// SHIFT_SEQ_SRL_EN enables the logical-right-shift opcode.
package shift_seq_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Stage k shifts by 2**k, so rem bit k selects stage k.
  localparam int NUM_STAGES = 5;
  localparam int STAGE_DIST [NUM_STAGES] = '{1, 2, 4, 8, 16};

  function automatic logic op_legal(input logic [1:0] op);
`ifdef SHIFT_SEQ_SRL_EN
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_SRL);
`else
    return (op == OP_SLL) || (op == OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// One fixed-distance shift: left with zero fill, or right with a caller-supplied fill bit.
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             left,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  assign q = left ? {data[WIDTH-1-DIST:0], {DIST{1'b0}}}
                  : {{DIST{fill}}, data[WIDTH-1:DIST]};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one binary-weighted stage per cycle, highest weight first.
// Define SHIFT_SEQ_SRL_EN to support op=10 (SRL); otherwise op=10 passes data through.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] data_operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [4:0]       rem;
  logic [1:0]       opr;

  logic [NUM_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] sel_q;
  logic [4:0]       rem_clr;
  logic             left;
  logic             fill;

  assign left = (opr == OP_SLL);
`ifdef SHIFT_SEQ_SRL_EN
  assign fill = (opr == OP_SRA) & acc[WIDTH-1];
`else
  // Only SLL and SRA reach SHIFT, so the right-shift fill is always the sign.
  assign fill = acc[WIDTH-1];
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .DIST(STAGE_DIST[k])) u_stage (
      .data (acc),
      .left (left),
      .fill (fill),
      .q    (stage_q[k])
    );
  end

  // Ascending scan: the last hit is the highest set bit of rem.
  always_comb begin
    sel_q   = acc;
    rem_clr = rem;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (rem[k]) begin
        sel_q      = stage_q[k];
        rem_clr    = rem;
        rem_clr[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      rem    <= '0;
      opr    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= data_operand;
            rem  <= shamt;
            opr  <= op;
            busy <= 1'b1;
            if (shamt == 5'd0 || !op_legal(op)) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= data_operand;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= sel_q;
          rem <= rem_clr;
          if (rem_clr == 5'd0) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= sel_q;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized checks of shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] data_operand = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  shift_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .shamt        (shamt),
    .data_operand (data_operand),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [1:0] o);
`ifdef SHIFT_SEQ_SRL_EN
    return o != 2'b11;
`else
    return o < 2'b10;
`endif
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [4:0] s,
                                             input logic [31:0] d);
    if (!ref_legal(o)) return d;
    case (o)
      2'b00:   return d << s;
      2'b01:   return 32'($signed(d) >>> s);
      default: return d >> s;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [4:0] s);
    if (!ref_legal(o) || s == 5'd0) return 1;
    return $countones(s) + 1;
  endfunction

  // Issue one op; inputs are scrambled after capture, optionally with a competing start.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                        input bit interfere, output int lat, output int bcnt,
                        output logic [31:0] res);
    lat = 0; bcnt = 0; res = 'x;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_operand = d;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      start = interfere; op = 2'($urandom); shamt = 5'($urandom); data_operand = $urandom;
      if (busy) bcnt++;
      if (done) begin
        lat = n; res = result; start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // After a done pulse: pulse ends, block idles, result holds, nothing was queued.
  task automatic chk_after(input string tag, input logic [31:0] exp_res);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " hold"}, result, exp_res);
    @(negedge clk);
    chk({tag, " no_queue"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                          input bit interfere, input string tag);
    int lat, bcnt;
    logic [31:0] res, exp_res;
    exp_res = ref_result(o, s, d);
    run_op(o, s, d, interfere, lat, bcnt, res);
    chk({tag, " lat"}, 32'(lat), 32'(ref_lat(o, s)));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(ref_lat(o, s)));
    chk({tag, " result"}, res, exp_res);
    chk_after(tag, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt;
    logic [31:0] res;

    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b01, 5'd8, 32'h8000_0000, 1'b0, lat, bcnt, res);
    chk("sra8 lat", 32'(lat), 32'd2);
    chk("sra8 result", res, 32'hFF80_0000);
    chk_after("sra8", 32'hFF80_0000);

    run_op(2'b00, 5'd31, 32'h0000_0001, 1'b0, lat, bcnt, res);
    chk("sll31 lat", 32'(lat), 32'd6);
    chk("sll31 busy_cycles", 32'(bcnt), 32'd6);
    chk("sll31 result", res, 32'h8000_0000);
    chk_after("sll31", 32'h8000_0000);

    run_op(2'b00, 5'd0, 32'h1234_5678, 1'b0, lat, bcnt, res);
    chk("sh0 lat", 32'(lat), 32'd1);
    chk("sh0 result", res, 32'h1234_5678);
    chk_after("sh0", 32'h1234_5678);

    run_op(2'b00, 5'd21, 32'h0000_0003, 1'b1, lat, bcnt, res);
    chk("ignore lat", 32'(lat), 32'd4);
    chk("ignore result", res, 32'h0060_0000);
    chk_after("ignore", 32'h0060_0000);

    run_op(2'b11, 5'd7, 32'hDEAD_BEEF, 1'b0, lat, bcnt, res);
    chk("op11 lat", 32'(lat), 32'd1);
    chk("op11 result", res, 32'hDEAD_BEEF);
    chk_after("op11", 32'hDEAD_BEEF);

    run_op(2'b10, 5'd4, 32'h8000_0000, 1'b0, lat, bcnt, res);
`ifdef SHIFT_SEQ_SRL_EN
    chk("op10 lat", 32'(lat), 32'd2);
    chk("op10 result", res, 32'h0800_0000);
    chk_after("op10", 32'h0800_0000);
`else
    chk("op10 lat", 32'(lat), 32'd1);
    chk("op10 result", res, 32'h8000_0000);
    chk_after("op10", 32'h8000_0000);
`endif

    // Abort an SLL by 31 two cycles in.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd31; data_operand = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    check_op(2'b00, 5'd31, 32'h0000_0001, 1'b0, "post_reset");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [4:0]  rs;
      logic [31:0] rd;
      ro = 2'($urandom_range(0, 3));
      rs = 5'($urandom);
      rd = $urandom;
      if ($urandom_range(0, 1) == 0) rd[31] = 1'b1;
      check_op(ro, rs, rd, $urandom_range(0, 3) == 0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
